data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   Word-wide data RAM for the single-cycle RV32 core, accessed by load/store instructions.
//   Writes are synchronous on the clock; reads are combinational, so a load completes in one cycle.
//   Storage is word-indexed: A selects a 32-bit word directly, with no byte-address shift.
//   Active-low reset gates the read port to zero and blocks writes.
// PARAMETERS
//   DATA_W     32     width of each word and of WD/RD
//   ADDR_BITS  10     index bits taken from A (A[ADDR_BITS-1:0])
//   DEPTH      1024   number of words (2**ADDR_BITS)
// PORTS
//   clk  input   1       clock; writes occur on the rising edge
//   rst  input   1       asynchronous, active-low reset (0 = in reset)
//   WE   input   1       write enable, active high
//   WD   input   32      write data
//   A    input   32      word index; only A[9:0] is used
//   RD   output  32      read data, combinational
// BEHAVIOUR
//   - Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst).
//   - Storage: mem[0:DEPTH-1] of DATA_W bits. All words are 0 at time zero (initial block).
//   - Reset behaviour:
//     - Reset does NOT clear array contents.
//     - While rst==0, RD is 0 immediately (async) regardless of A.
//     - While rst==0, writes are blocked.
//   - Write:
//     - At posedge clk, if rst==1 and WE==1, then mem[A[9:0]] <= WD.
//     - Otherwise no array change.
//   - Read:
//     - RD = (rst==0) ? 0 : mem[A[9:0]], purely combinational, with zero-cycle latency.
//     - A change on A reflects on RD in the same delta/cycle.
//   - Read-during-write to the same index: before the edge RD shows old data; after the edge
//     RD shows WD. There is no bypass.
//   - Upper address bits A[31:10] are ignored, so addresses alias modulo DEPTH. No error flag.
//   - Boundaries: index 0 and index 1023 are both fully usable.
//   - Overwrite: the last write wins. There are no byte enables; every write is a full 32-bit word.
//   - Reset asserted while WE==1 across a clock edge: no write occurs. After release, RD shows
//     the prior contents of that index.
//   - WE and rst are sampled only at the posedge (rst also acts asynchronously on RD).
//     Changing WE or A between edges has no effect on the array.
//   - No X propagation from uninitialised words, since all words start at 0.
// TESTING
//   1. Reset: rst=0, A=0 -> RD==0. Then rst=1, A=0x14 (never written) -> RD==0.
//   2. Basic write/read: WE=1, A=0x10, WD=0x12345678, one posedge, then WE=0 -> RD==0x12345678.
//      Rewrite with WD=0xFFFFFFFF -> RD==0xFFFFFFFF.
//   3. Independence: write 0x20<-0xABCDEF00 and 0x30<-0xCAFEBABE, then set A=0x20
//      -> RD==0xABCDEF00; set A=0x30 -> RD==0xCAFEBABE.
//   4. Boundaries: write A=0<-0x00000001 and A=0x3FF<-0x1023ABCD -> both read back exactly.
//      A=0x400 -> reads the same word as A=0 (alias).
//   5. Reset mid-write: A=0x200, WD=0xBADBAD00, WE=1, rst=0 held across two edges,
//      then rst=1, WE=0 -> RD==0x00000000 (write blocked).
//   6. Edge timing: WE=1, A=0x300, WD=0xCCCCCCCC. Drop WE 1 ns after the posedge;
//      5 ns later RD==0xCCCCCCCC. Before that edge, RD==0.

Source files
------------

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Word-indexed data RAM for the single-cycle RV32 core.
//   - Synchronous write on the rising edge of clk, qualified by WE and rst.
//   - Combinational read with zero-cycle latency.
//   - Active-low rst forces RD to zero immediately and blocks writes. It does
//     not clear the array contents.
//   - A selects a word directly. Only A[ADDR_BITS-1:0] is used, so higher
//     addresses alias modulo DEPTH.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DEPTH     = 2 ** ADDR_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic [DATA_W-1:0] WD,
    input  logic [31:0]       A,
    output logic [DATA_W-1:0] RD
);

    // Storage is zero-filled at configuration time so that no word ever reads
    // as X. Reset deliberately leaves the contents alone.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_BITS-1:0] idx;
    logic                 unused_a_hi;

    // Word index taken from the low address bits. The upper bits alias away.
    always_comb begin
        idx         = A[ADDR_BITS-1:0];
        unused_a_hi = ^A[31:ADDR_BITS];
    end

    // The write port samples rst as an enable at the clock edge. Reset only
    // blocks the write and clears nothing, so an asynchronous reset branch
    // would have no state to act on. The read port below gives rst its
    // immediate effect.
    always_ff @(posedge clk) begin
        if (rst && WE) begin
            mem[idx] <= WD;
        end
    end

    // Combinational read, forced to zero while reset is asserted. No
    // write-to-read bypass: a same-index write becomes visible after the edge.
    always_comb begin
        RD = '0;
        if (rst) begin
            RD = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//   Randomized self-checking bench for data_memory. The reference is a plain
//   word array updated on each rising edge that sees rst==1 and WE==1. A
//   compare process checks RD against that model on every falling edge, and
//   directed steps pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] A;
    logic [31:0] RD;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [31:0] model [1024];

    data_memory #(
        .DATA_W   (32),
        .ADDR_BITS(10),
        .DEPTH    (1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .WE (WE),
        .WD (WD),
        .A  (A),
        .RD (RD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = '0;
    end

    // Reference model: a word is stored only when reset is released and WE is
    // high at the rising edge. Inputs are always stable around that edge.
    always @(posedge clk) begin
        if (rst === 1'b1 && WE === 1'b1) model[A[9:0]] = WD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: RD=%08h expected %08h (t=%0t A=%08h rst=%b)", name, act, exp, $time, A, rst);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic r, input logic [31:0] a);
        logic [31:0] v;
        v = (r === 1'b1) ? model[a[9:0]] : 32'h0;
        return v;
    endfunction

    // Continuous comparison on every falling edge, away from the write edge.
    always @(negedge clk) begin
        check("model", RD, model_rd(rst, A));
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] addr;
        logic [9:0]  pool [8];

        rst = 1'b0; WE = 1'b0; A = 32'h0; WD = 32'h0;

        // 1. Reset
        #1 check("reset_rd", RD, 32'h0);
        tick();
        rst = 1'b1; A = 32'h14;
        #1 check("unwritten_rd", RD, 32'h0);

        // 2. Basic write/read and rewrite
        tick();
        WE = 1'b1; A = 32'h10; WD = 32'h12345678;
        tick();
        WE = 1'b0;
        #1 check("basic_wr", RD, 32'h12345678);
        WE = 1'b1; WD = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0;
        #1 check("rewrite", RD, 32'hFFFF_FFFF);

        // 3. Independence
        WE = 1'b1; A = 32'h20; WD = 32'hABCDEF00;
        tick();
        A = 32'h30; WD = 32'hCAFEBABE;
        tick();
        WE = 1'b0; A = 32'h20;
        #1 check("indep_20", RD, 32'hABCDEF00);
        A = 32'h30;
        #1 check("indep_30", RD, 32'hCAFEBABE);

        // 4. Boundaries and aliasing
        WE = 1'b1; A = 32'h0; WD = 32'h0000_0001;
        tick();
        A = 32'h3FF; WD = 32'h1023ABCD;
        tick();
        WE = 1'b0; A = 32'h0;
        #1 check("bound_0", RD, 32'h0000_0001);
        A = 32'h3FF;
        #1 check("bound_3ff", RD, 32'h1023ABCD);
        A = 32'h400;
        #1 check("alias_400", RD, 32'h0000_0001);
        A = 32'hFFFF_FFFF;
        #1 check("alias_hi", RD, 32'h1023ABCD);

        // 5. Reset held across edges blocks the write
        tick();
        A = 32'h200; WD = 32'hBADBAD00; WE = 1'b1; rst = 1'b0;
        #1 check("rst_rd_zero", RD, 32'h0);
        tick();
        tick();
        rst = 1'b1; WE = 1'b0;
        #1 check("rst_blocks_wr", RD, 32'h0);

        // Async reset zeroes RD mid-cycle without clearing contents
        A = 32'h10;
        #1 check("pre_async", RD, 32'hFFFF_FFFF);
        rst = 1'b0;
        #1 check("async_rd", RD, 32'h0);
        rst = 1'b1;
        #1 check("post_async", RD, 32'hFFFF_FFFF);

        // 6. Edge timing: no bypass before the edge
        tick();
        WE = 1'b1; A = 32'h300; WD = 32'hCCCCCCCC;
        #2 check("pre_edge", RD, 32'h0);
        @(posedge clk);
        #1 WE = 1'b0;
        #5 check("post_edge", RD, 32'hCCCCCCCC);

        // Randomized traffic over a small hot index pool plus fully random addresses
        for (int i = 0; i < 8; i++) pool[i] = 10'($urandom);
        pool[0] = 10'h000;
        pool[1] = 10'h3FF;
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 15) != 0);
            WE  = $urandom_range(0, 1);
            WD  = $urandom;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[9:0] = pool[$urandom_range(0, 7)];
            A = addr;
            // Occasionally move A mid-cycle and check the combinational read
            if ($urandom_range(0, 7) == 0) begin
                #2;
                WE = 1'b0;
                addr = $urandom;
                addr[9:0] = pool[$urandom_range(0, 7)];
                A = addr;
                #1 check("mid_cycle", RD, model_rd(rst, A));
            end
        end

        tick();
        rst = 1'b1; WE = 1'b0;
        // Final readback of the hot pool against the model
        for (int i = 0; i < 8; i++) begin
            A = {22'h0, pool[i]};
            #1 check("final_pool", RD, model[pool[i]]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
